// File: rtl/smm_cif_div_pkg.sv
// Shared types and constants for the SMM_CIF sequential divider family.
package smm_cif_div_pkg;

    localparam int DIV_DIVIDEND_W = 64;
    localparam int DIV_DIVISOR_W  = 32;
    localparam int CNT_W          = $clog2(DIV_DIVIDEND_W);

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/smm_cif_div_step.sv
// One combinational restoring-division step: shift in one dividend bit, trial-subtract.
module smm_cif_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         qbit
);

    logic [W+1:0] diff;
    logic         borrow;

    // One extra bit of headroom so the sign of the trial is never lost.
    assign diff   = {r, msb} - {2'b00, divisor};
    assign borrow = diff[W+1];
    assign qbit   = ~borrow;
    assign r_next = borrow ? {r[W-1:0], msb} : diff[W:0];

endmodule

// File: rtl/smm_cif_udiv_64ns_32ns_seq.sv
// Sequential unsigned restoring divider, one quotient bit per enabled cycle,
// valid/ready on both sides.
module smm_cif_udiv_64ns_32ns_seq
    import smm_cif_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_W,
    parameter int DIVISOR_WIDTH  = DIV_DIVISOR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH);

    div_state_t                state_reg;
    logic [DIVIDEND_WIDTH-1:0] shreg_reg;
    logic [DIVISOR_WIDTH:0]    r_reg;
    logic [DIVISOR_WIDTH-1:0]  divisor_reg;
    logic [CW-1:0]             cnt_reg;

    logic [DIVISOR_WIDTH:0]    r_next;
    logic                      qbit;
    logic [DIVIDEND_WIDTH-1:0] shreg_next;

    smm_cif_div_step #(
        .W       (DIVISOR_WIDTH)
    ) u_step (
        .r       (r_reg),
        .msb     (shreg_reg[DIVIDEND_WIDTH-1]),
        .divisor (divisor_reg),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign shreg_next = {shreg_reg[DIVIDEND_WIDTH-2:0], qbit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            r_reg       <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shreg_reg   <= dividend;
                        divisor_reg <= divisor;
                        r_reg       <= '0;
                        cnt_reg     <= CW'(DIVIDEND_WIDTH - 1);
                        in_ready    <= 1'b0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state_reg   <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_WIDTH-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    shreg_reg <= shreg_next;
                    r_reg     <= r_next;
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        quotient  <= shreg_next;
                        remainder <= r_next[DIVISOR_WIDTH-1:0];
                        out_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smm_cif_udiv_64ns_32ns_seq.sv
// Directed bench for the sequential 64/32 unsigned divider.
module tb_smm_cif_udiv_64ns_32ns_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    smm_cif_udiv_64ns_32ns_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, then count raw edges (accept edge = 1) until out_valid.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b, input bit hold_valid,
                          input int ce_gap_at, output int lat);
        int guard;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        lat = 1;
        if (!hold_valid) in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 300) begin
            if (ce_gap_at != 0 && lat == ce_gap_at) begin
                ce = 1'b0;
                repeat (5) begin
                    tick();
                    lat++;
                end
                ce = 1'b1;
            end
            tick();
            lat++;
            guard++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [63:0] q, input logic [31:0] r,
                                input logic dz, input int lat, input int exp_lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, 64'(remainder), 64'(r));
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
        $display("op %s: q=0x%0h r=0x%0h dz=%0b lat=%0d", tag, quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        int          lat;
        logic [63:0] q_hold;
        logic [31:0] r_hold;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #23;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        tick();

        // 100 / 7
        run_op(64'd100, 32'd7, 1'b0, 0, lat);
        check_result("100div7", 64'd14, 32'd2, 1'b0, lat, 65);
        ack();
        chk("ack_out_valid", 64'(out_valid), 64'd0);
        chk("ack_in_ready", 64'(in_ready), 64'd1);

        // Square of max 32-bit back down
        run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0, 0, lat);
        check_result("sq_div", 64'h0000_0000_FFFF_FFFF, 32'd0, 1'b0, lat, 65);
        ack();

        // Divide by zero, then a normal op clears the flag
        run_op(64'h1234, 32'd0, 1'b0, 0, lat);
        check_result("div0", 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234, 1'b1, lat, 1);
        ack();
        run_op(64'd10, 32'd3, 1'b0, 0, lat);
        check_result("10div3", 64'd3, 32'd1, 1'b0, lat, 65);

        // Backpressure: hold result for 20 cycles
        q_hold = quotient;
        r_hold = remainder;
        repeat (20) tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_q", quotient, q_hold);
        chk("bp_r", 64'(remainder), 64'(r_hold));
        chk("bp_q_exp", quotient, 64'd3);
        $display("op backpressure: held 20 cycles q=0x%0h r=0x%0h", quotient, remainder);
        ack();

        // ce low for 5 cycles mid-BUSY
        run_op(64'd1000, 32'd7, 1'b0, 10, lat);
        check_result("ce_gap", 64'd142, 32'd6, 1'b0, lat, 70);
        ack();

        // in_valid held through BUSY and DONE must not restart the divide
        run_op(64'd77, 32'd5, 1'b1, 0, lat);
        check_result("hold_valid", 64'd15, 32'd2, 1'b0, lat, 65);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        dividend = 64'd999;
        divisor  = 32'd1;
        tick();
        chk("hold_q_stable", quotient, 64'd15);
        in_valid = 1'b0;
        ack();

        // Reset mid-BUSY
        dividend = 64'd5000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (29) tick();
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_q", quotient, 64'd0);
        $display("op reset_mid_busy: in_ready=%0b out_valid=%0b", in_ready, out_valid);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_op(64'd100, 32'd10, 1'b0, 0, lat);
        check_result("100div10", 64'd10, 32'd0, 1'b0, lat, 65);
        ack();

        // Edge operands
        run_op(64'd5, 32'd9, 1'b0, 0, lat);
        check_result("5div9", 64'd0, 32'd5, 1'b0, lat, 65);
        ack();
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 0, lat);
        check_result("maxdiv1", 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, lat, 65);
        ack();
        run_op(64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
        check_result("maxdivmax", 64'd1, 32'd0, 1'b0, lat, 65);
        ack();

        // Random products a*b / b
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            run_op(64'(ra) * 64'(rb), rb, 1'b0, 0, lat);
            check_result("rand_prod", 64'(ra), 32'd0, 1'b0, lat, 65);
            ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
